// File: rtl/cpu_step_controller.sv
// Debounced push-button front end that issues one-cycle clock enables to the core.
// Define STEP_CTRL_BREAKPOINT_EN to enable the PC breakpoint compare and BREAK state.
module cpu_step_controller #(
    parameter int unsigned N_BTN     = 4,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned RUN_DIV   = 25000000,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic [N_BTN-1:0]  i_button,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_bp_addr,
    input  logic              i_bp_valid,
    output logic [N_BTN-1:0]  o_button,
    output logic [N_BTN-1:0]  o_press,
    output logic              o_cpu_en,
    output logic              o_halted,
    output logic [31:0]       o_step_count
);

    localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int unsigned BC_W  = $clog2(BURST_LEN + 1);

    localparam logic [DB_W-1:0]  DbLast   = DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DivLast  = DIV_W'(RUN_DIV - 1);
    localparam logic [BC_W-1:0]  BurstLen = BC_W'(BURST_LEN);

    typedef enum logic [2:0] {StIdle, StStep, StRun, StBurst, StBreak} state_e;

    logic [N_BTN-1:0] sync1, sync2, button_d;
    logic [DB_W-1:0]  db_cnt [N_BTN];

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic             go, stop, fire, bp_hit, en_d, halted_d;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            o_button <= '0;
            button_d <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= i_button;
            sync2    <= sync1;
            button_d <= o_button;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] != o_button[i]) begin
                    if (db_cnt[i] == DbLast) begin
                        o_button[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign o_press = o_button & ~button_d;
    // STOP wins over a simultaneous GO.
    assign stop    = o_press[1];
    assign go      = o_press[0] & ~o_press[1];

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign bp_hit = i_bp_valid && (i_pc == i_bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{i_pc, i_bp_addr, i_bp_valid};
    assign bp_hit    = 1'b0;
`endif

    // Cycles on which RUN/BURST would issue an enable, before the breakpoint compare.
    assign fire = !stop && (((state_q == StRun) && (div_q == DivLast)) || (state_q == StBurst));

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q      <= StIdle;
            div_q        <= '0;
            bcnt_q       <= '0;
            o_cpu_en     <= 1'b0;
            o_halted     <= 1'b0;
            o_step_count <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bcnt_q   <= bcnt_d;
            o_cpu_en <= en_d;
            o_halted <= halted_d;
            if (en_d) o_step_count <= o_step_count + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            StIdle: begin
                if (go) begin
                    case (i_mode)
                        2'b00:   state_d = StStep;
                        2'b01: begin
                            state_d = StRun;
                            div_d   = '0;
                        end
                        2'b10: begin
                            state_d = StBurst;
                            bcnt_d  = BurstLen;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StStep: state_d = StIdle;
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (div_q == DivLast) begin
                    div_d = '0;
                    if (bp_hit) state_d = StBreak;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StBurst: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (bp_hit) begin
                    state_d = StBreak;
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                    if (bcnt_q == BC_W'(1)) state_d = StIdle;
                end
            end
            StBreak: begin
                if (stop)    state_d = StIdle;
                else if (go) state_d = StStep;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en_d = (state_q == StStep) || (fire && !bp_hit);
`ifdef STEP_CTRL_BREAKPOINT_EN
        halted_d = (state_d == StBreak);
`else
        halted_d = 1'b0;
`endif
    end

endmodule
